// File: rtl/vsub_seq_pkg.sv
// Shared definitions for the multicycle vector subtractor: default geometry,
// FSM state encodings and a helper for sizing the lane index counter.
package vsub_seq_pkg;

  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned LANE_W_DEF = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Lane index width; a single-lane build still gets a 1-bit counter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vsub_lane.sv
// Single-lane unsigned subtract: res = a - b, with borrow out and optional
// clamp-to-zero when the lane borrows.
//   a, b    : lane operands (LANE_W bits)
//   res     : lane result (wrapped, or 0 on borrow when SATURATE=1)
//   borrow  : 1 iff a < b
module vsub_lane #(
  parameter int unsigned LANE_W   = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] res,
  output logic              borrow
);

  logic [LANE_W:0] diff;

  // One extra bit exposes the borrow as the MSB of the difference.
  always_comb begin
    diff   = {1'b0, a} - {1'b0, b};
    borrow = diff[LANE_W];
    res    = (SATURATE && diff[LANE_W]) ? '0 : diff[LANE_W-1:0];
  end

endmodule

// File: rtl/vsub_seq.sv
// Multicycle lane-wise vector subtractor: out = in1 - in2, one lane per cycle
// through a single shared lane subtractor.
//   clock, reset : rising-edge clock, async active-high reset
//   start        : request, accepted only while idle
//   in1, in2     : minuend / subtrahend vectors, latched on accept
//   out          : result vector
//   borrow       : per-lane borrow flags
//   zero         : all lanes of the final result are zero
//   busy         : operation in progress
//   done         : one-cycle pulse when out/borrow/zero are valid
module vsub_seq
  import vsub_seq_pkg::*;
#(
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned LANE_W   = LANE_W_DEF,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LANES*LANE_W-1:0] in1,
  input  logic [LANES*LANE_W-1:0] in2,
  output logic [LANES*LANE_W-1:0] out,
  output logic [LANES-1:0]        borrow,
  output logic                    zero,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DW    = LANES * LANE_W;
  localparam int unsigned IDX_W = idx_width(LANES);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d;
  logic [DW-1:0]     out_d;
  logic [LANES-1:0]  borrow_d;
  logic              zero_d, busy_d, done_d;

  logic [LANE_W-1:0] a_lane, b_lane, res_lane;
  logic              brw_lane;

  // Select the lane currently being processed from the latched operands.
  always_comb begin
    a_lane = a_q[LANE_W*int'(idx_q) +: LANE_W];
    b_lane = b_q[LANE_W*int'(idx_q) +: LANE_W];
  end

  vsub_lane #(
    .LANE_W   (LANE_W),
    .SATURATE (SATURATE)
  ) u_lane (
    .a      (a_lane),
    .b      (b_lane),
    .res    (res_lane),
    .borrow (brw_lane)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out;
    borrow_d = borrow;
    zero_d   = zero;
    busy_d   = busy;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = in1;
          b_d      = in2;
          out_d    = '0;
          borrow_d = '0;
          zero_d   = 1'b0;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        out_d[LANE_W*int'(idx_q) +: LANE_W] = res_lane;
        borrow_d[idx_q]                     = brw_lane;
        idx_d                               = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(LANES - 1)) begin
          // Zero flag is taken from the result including this final lane.
          zero_d  = (out_d == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      out    <= '0;
      borrow <= '0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      a_q    <= a_d;
      b_q    <= b_d;
      out    <= out_d;
      borrow <= borrow_d;
      zero   <= zero_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule
